kronos_lsu: RTL

Load/store sequencer between the Kronos write-back stage and the data memory bus. Accepts one load or store request at a time, splits accesses that cross a 32-bit word boundary into two word-aligned bus transactions, and produces byte-lane masks and shifted store data. For loads it merges, extracts and sign/zero-extends the result and returns it with the destination register. The write-back stage stalls on `start_rdy` while a transfer is in flight.

---
 rtl/kronos_lsu.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/kronos_lsu.sv
// Load/store sequencer between write-back and the data bus: splits word-crossing
// accesses into two aligned transactions, lane-aligns stores and extends loads.
module kronos_lsu (
  input  logic        clk,
  input  logic        rstz,
  input  logic        start_vld,
  output logic        start_rdy,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        st,
  input  logic [1:0]  size,
  input  logic        ld_sign,
  input  logic [4:0]  rd,
  output logic        done,
  output logic [31:0] ld_data,
  output logic [4:0]  ld_rd,
  output logic        ld_wr,
  output logic        data_req,
  output logic [31:0] data_addr,
  output logic        data_we,
  output logic [3:0]  data_mask,
  output logic [31:0] data_wr_data,
  input  logic [31:0] data_rd_data,
  input  logic        data_ack
);

  // Handshakes: a request is accepted on a posedge with start_vld && start_rdy;
  // a bus beat completes on a posedge with data_req && data_ack, and the bus
  // outputs are held constant from the first data_req cycle through that edge.

  typedef enum logic [1:0] {IDLE, LO, HI} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        st_q, st_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] lo_q, lo_d;
  // The top byte of the upper word can never be reached by any access.
  logic [23:0] hi_q, hi_d;
  logic        done_q, done_d;
  logic        ld_wr_q, ld_wr_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic [4:0]  ld_rd_q, ld_rd_d;

  logic [1:0]  off;
  logic [3:0]  sm;
  logic [7:0]  m8;
  logic [63:0] w64;
  logic        span;
  logic [31:0] word_addr;
  logic        fin;
  logic [31:0] lo_m;
  logic [23:0] hi_m;
  logic [31:0] r32;
  logic [31:0] ext;

  always_comb begin
    off = addr_q[1:0];
    case (size_q)
      2'd0:    sm = 4'b0001;
      2'd1:    sm = 4'b0011;
      default: sm = 4'b1111;
    endcase
    m8        = {4'b0000, sm} << off;
    w64       = {32'b0, wdata_q} << {off, 3'b000};
    span      = |m8[7:4];
    word_addr = {addr_q[31:2], 2'b00};
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    st_d         = st_q;
    size_d       = size_q;
    sign_d       = sign_q;
    rd_d         = rd_q;
    lo_d         = lo_q;
    hi_d         = hi_q;
    fin          = 1'b0;
    start_rdy    = 1'b0;
    data_req     = 1'b0;
    data_addr    = 32'b0;
    data_we      = 1'b0;
    data_mask    = 4'b0;
    data_wr_data = 32'b0;
    case (state_q)
      IDLE: begin
        start_rdy = 1'b1;
        if (start_vld) begin
          addr_d  = addr;
          wdata_d = wdata;
          st_d    = st;
          size_d  = size;
          sign_d  = ld_sign;
          rd_d    = rd;
          state_d = LO;
        end
      end
      LO: begin
        data_req     = 1'b1;
        data_addr    = word_addr;
        data_we      = st_q;
        data_mask    = m8[3:0];
        data_wr_data = w64[31:0];
        if (data_ack) begin
          lo_d = data_rd_data;
          if (span) begin
            state_d = HI;
          end else begin
            fin     = 1'b1;
            state_d = IDLE;
          end
        end
      end
      HI: begin
        data_req     = 1'b1;
        data_addr    = word_addr + 32'd4;
        data_we      = st_q;
        data_mask    = m8[7:4];
        data_wr_data = w64[63:32];
        if (data_ack) begin
          hi_d    = data_rd_data[23:0];
          fin     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The completing beat's read data bypasses its capture register so the
  // extended result can be registered in the same edge as done.
  always_comb begin
    lo_m = (state_q == LO) ? data_rd_data : lo_q;
    hi_m = (state_q == HI) ? data_rd_data[23:0] : hi_q;
    case (off)
      2'd0:    r32 = lo_m;
      2'd1:    r32 = {hi_m[7:0],  lo_m[31:8]};
      2'd2:    r32 = {hi_m[15:0], lo_m[31:16]};
      default: r32 = {hi_m[23:0], lo_m[31:24]};
    endcase
    case (size_q)
      2'd0:    ext = {{24{sign_q & r32[7]}}, r32[7:0]};
      2'd1:    ext = {{16{sign_q & r32[15]}}, r32[15:0]};
      default: ext = r32;
    endcase
    done_d    = fin;
    ld_wr_d   = fin & ~st_q;
    ld_rd_d   = fin ? rd_q : ld_rd_q;
    ld_data_d = (fin && !st_q) ? ext : ld_data_q;
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q   <= IDLE;
      addr_q    <= 32'b0;
      wdata_q   <= 32'b0;
      st_q      <= 1'b0;
      size_q    <= 2'b0;
      sign_q    <= 1'b0;
      rd_q      <= 5'b0;
      lo_q      <= 32'b0;
      hi_q      <= 24'b0;
      done_q    <= 1'b0;
      ld_wr_q   <= 1'b0;
      ld_data_q <= 32'b0;
      ld_rd_q   <= 5'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      st_q      <= st_d;
      size_q    <= size_d;
      sign_q    <= sign_d;
      rd_q      <= rd_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      done_q    <= done_d;
      ld_wr_q   <= ld_wr_d;
      ld_data_q <= ld_data_d;
      ld_rd_q   <= ld_rd_d;
    end
  end

  assign done    = done_q;
  assign ld_wr   = ld_wr_q;
  assign ld_data = ld_data_q;
  assign ld_rd   = ld_rd_q;

endmodule
